// File: rtl/soc_uart_check_monitor_pkg.sv
// Shared types for the UART check monitor: receiver states, per-frame outcome
// classification and the synchronizer depth.
package soc_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_MISMATCH,
    ERR_UNEXPECTED,
    ERR_FRAME,
    ERR_PARITY
  } err_kind_e;

  localparam int SYNC_STAGES = 2;

  // An empty FIFO wins over line errors so err_unexpected is reported even on a
  // broken frame; line errors suppress the data compare.
  function automatic err_kind_e classify_frame(input logic has_head,
                                               input logic frame_err,
                                               input logic par_err,
                                               input logic equal);
    err_kind_e kind;
    kind = ERR_NONE;
    if (!has_head)      kind = ERR_UNEXPECTED;
    else if (frame_err) kind = ERR_FRAME;
    else if (par_err)   kind = ERR_PARITY;
    else if (!equal)    kind = ERR_MISMATCH;
    return kind;
  endfunction

endpackage

// File: rtl/soc_uart_check_monitor_if.sv
// Expected-byte push handshake plus the received-frame result, shared between
// the stimulus side (master) and the monitor (slave).
interface soc_uart_check_monitor_if #(
  parameter int DATA_BITS = 8
);
  logic                 exp_valid;
  logic [DATA_BITS-1:0] exp_data;
  logic                 exp_ready;
  logic                 rx_strobe;
  logic [DATA_BITS-1:0] rx_data;

  modport master (
    output exp_valid,
    output exp_data,
    input  exp_ready,
    input  rx_strobe,
    input  rx_data
  );

  modport slave (
    input  exp_valid,
    input  exp_data,
    output exp_ready,
    output rx_strobe,
    output rx_data
  );
endinterface

// File: rtl/soc_uart_check_monitor_sync_fifo.sv
// Small FIFO of expected bytes with a show-ahead head so the compare can use it
// in the same cycle the frame completes.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/soc_uart_check_monitor.sv
// UART receive monitor: decodes the serial line, compares each byte against the
// expected-byte FIFO and keeps counters, sticky error flags and an idle timeout.
module soc_uart_check_monitor
  import soc_test_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int EXP_DEPTH    = 16,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_i,
  input  logic [15:0]             cfg_div,
  input  logic                    cfg_par_en,
  input  logic                    cfg_par_odd,
  soc_uart_check_monitor_if.slave exp_if,
  output logic [CNT_W-1:0]        match_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    err_mismatch,
  output logic                    err_unexpected,
  output logic                    err_frame,
  output logic                    err_parity,
  output logic                    timeout,
  output logic                    busy,
  output logic                    pending
);
  localparam int         TB_W     = $clog2(TIMEOUT_BITS + 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [SYNC_STAGES:0]   sync_chain;
  logic                   rx_s;
  logic                   rx_prev_reg;
  logic                   fall_edge;

  rx_state_e              state_reg, state_next;
  logic [15:0]            cnt_reg, cnt_next;
  logic [3:0]             bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_acc_reg, par_acc_next;
  logic                   frame_err_reg, frame_err_next;
  logic                   par_err_reg, par_err_next;
  logic                   done_reg, done_next;
  logic [DATA_BITS-1:0]   rx_data_reg, rx_data_next;
  logic [15:0]            half_div;

  logic [CNT_W-1:0]       match_cnt_reg, err_cnt_reg;
  logic                   mismatch_reg, unexpected_reg, frame_flag_reg, parity_flag_reg;
  logic [15:0]            tick_reg;
  logic [TB_W-1:0]        idle_bits_reg;
  logic                   timeout_reg;

  logic [DATA_BITS-1:0]   fifo_head;
  logic                   fifo_full, fifo_empty;
  err_kind_e              frame_kind;

  assign sync_chain[0] = rx_i;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) sync_chain[gi+1] <= 1'b1;
        else       sync_chain[gi+1] <= sync_chain[gi];
      end
    end
  endgenerate

  assign rx_s      = sync_chain[SYNC_STAGES];
  assign fall_edge = rx_prev_reg && !rx_s;
  assign half_div  = {1'b0, cfg_div[15:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev_reg   <= 1'b1;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      par_acc_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      par_err_reg   <= 1'b0;
      done_reg      <= 1'b0;
      rx_data_reg   <= '0;
    end else begin
      rx_prev_reg   <= rx_s;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      par_acc_reg   <= par_acc_next;
      frame_err_reg <= frame_err_next;
      par_err_reg   <= par_err_next;
      done_reg      <= done_next;
      rx_data_reg   <= rx_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    par_acc_next   = par_acc_reg;
    frame_err_next = frame_err_reg;
    par_err_next   = par_err_reg;
    done_next      = 1'b0;
    rx_data_next   = rx_data_reg;
    case (state_reg)
      IDLE: begin
        // A low stop bit leaves rx_prev low, so a new start needs the line to rise first.
        if (fall_edge) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == half_div - 16'd1) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next     = DATA;
            bit_idx_next   = '0;
            par_acc_next   = 1'b0;
            frame_err_next = 1'b0;
            par_err_next   = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (cnt_reg == cfg_div - 16'd1) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
          par_acc_next = par_acc_reg ^ rx_s;
          if (bit_idx_reg == LAST_BIT) state_next = cfg_par_en ? PARITY : STOP;
          else                         bit_idx_next = bit_idx_reg + 4'd1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      PARITY: begin
        if (cnt_reg == cfg_div - 16'd1) begin
          cnt_next     = '0;
          par_err_next = (rx_s != (par_acc_reg ^ cfg_par_odd));
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      STOP: begin
        if (cnt_reg == cfg_div - 16'd1) begin
          cnt_next       = '0;
          frame_err_next = !rx_s;
          done_next      = 1'b1;
          rx_data_next   = shift_reg;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // exp_ready reflects the pre-pop occupancy: a pop at full never frees a slot the same cycle.
  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (EXP_DEPTH)
  ) u_exp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (exp_if.exp_valid && !fifo_full),
    .push_data (exp_if.exp_data),
    .pop       (done_reg && !fifo_empty),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign frame_kind = classify_frame(!fifo_empty, frame_err_reg, par_err_reg,
                                     rx_data_reg == fifo_head);

  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt_reg   <= '0;
      err_cnt_reg     <= '0;
      mismatch_reg    <= 1'b0;
      unexpected_reg  <= 1'b0;
      frame_flag_reg  <= 1'b0;
      parity_flag_reg <= 1'b0;
    end else if (done_reg) begin
      if (frame_kind == ERR_NONE && match_cnt_reg != '1)
        match_cnt_reg <= match_cnt_reg + CNT_W'(1);
      if (frame_kind != ERR_NONE && err_cnt_reg != '1)
        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      if (frame_kind == ERR_MISMATCH)   mismatch_reg    <= 1'b1;
      if (frame_kind == ERR_UNEXPECTED) unexpected_reg  <= 1'b1;
      if (frame_err_reg)                frame_flag_reg  <= 1'b1;
      if (par_err_reg)                  parity_flag_reg <= 1'b1;
    end
  end

  // Idle timer counts whole bit-times of quiet line while bytes are still owed.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_reg      <= '0;
      idle_bits_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      if (fifo_empty || (state_reg == IDLE && fall_edge)) begin
        tick_reg      <= '0;
        idle_bits_reg <= '0;
      end else if (state_reg == IDLE) begin
        if (tick_reg == cfg_div - 16'd1) begin
          tick_reg <= '0;
          if (idle_bits_reg != TB_W'(TIMEOUT_BITS)) idle_bits_reg <= idle_bits_reg + TB_W'(1);
        end else begin
          tick_reg <= tick_reg + 16'd1;
        end
      end
      if (idle_bits_reg == TB_W'(TIMEOUT_BITS)) timeout_reg <= 1'b1;
    end
  end

  assign exp_if.exp_ready = !fifo_full;
  assign exp_if.rx_strobe = done_reg;
  assign exp_if.rx_data   = rx_data_reg;
  assign match_cnt        = match_cnt_reg;
  assign err_cnt          = err_cnt_reg;
  assign err_mismatch     = mismatch_reg;
  assign err_unexpected   = unexpected_reg;
  assign err_frame        = frame_flag_reg;
  assign err_parity       = parity_flag_reg;
  assign timeout          = timeout_reg;
  assign busy             = (state_reg != IDLE);
  assign pending          = !fifo_empty;

endmodule

// File: tb/tb_soc_uart_check_monitor.sv
// Scoreboard bench: stimulus tasks push frame expectations from a queue-based
// reference model; an independent monitor pops and checks on every rx_strobe.
module tb_soc_uart_check_monitor;
  localparam int DATA_BITS    = 8;
  localparam int EXP_DEPTH    = 16;
  localparam int CNT_W        = 16;
  localparam int TIMEOUT_BITS = 64;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_i;
  logic [15:0]      cfg_div;
  logic             cfg_par_en;
  logic             cfg_par_odd;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_mismatch, err_unexpected, err_frame, err_parity;
  logic             timeout, busy, pending;

  soc_uart_check_monitor_if #(.DATA_BITS(DATA_BITS)) bus ();

  soc_uart_check_monitor #(
    .DATA_BITS    (DATA_BITS),
    .EXP_DEPTH    (EXP_DEPTH),
    .CNT_W        (CNT_W),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_i           (rx_i),
    .cfg_div        (cfg_div),
    .cfg_par_en     (cfg_par_en),
    .cfg_par_odd    (cfg_par_odd),
    .exp_if         (bus),
    .match_cnt      (match_cnt),
    .err_cnt        (err_cnt),
    .err_mismatch   (err_mismatch),
    .err_unexpected (err_unexpected),
    .err_frame      (err_frame),
    .err_parity     (err_parity),
    .timeout        (timeout),
    .busy           (busy),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         match;
    int         err;
    bit         mis;
    bit         unexp;
    bit         frm;
    bit         par;
    bit         pend;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_q[$];
  int         m_match, m_err;
  bit         m_mis, m_unexp, m_frm, m_par;
  int         n_checks = 0;
  int         n_fail = 0;
  int         strobe_count = 0;
  bit         mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    model_q.delete();
    sb.delete();
    m_match = 0; m_err = 0;
    m_mis = 0; m_unexp = 0; m_frm = 0; m_par = 0;
  endtask

  // Reference: each completed frame consumes one expected byte (if any) and
  // contributes at most one error count.
  task automatic model_frame(input logic [7:0] d, input bit frm_err, input bit par_err);
    exp_t       e;
    logic [7:0] head;
    if (model_q.size() == 0) begin
      m_unexp = 1;
      m_err   = sat_inc(m_err);
    end else begin
      head = model_q.pop_front();
      if (frm_err || par_err) m_err = sat_inc(m_err);
      else if (head == d)     m_match = sat_inc(m_match);
      else begin
        m_mis = 1;
        m_err = sat_inc(m_err);
      end
    end
    if (frm_err) m_frm = 1;
    if (par_err) m_par = 1;
    e.data = d; e.match = m_match; e.err = m_err;
    e.mis = m_mis; e.unexp = m_unexp; e.frm = m_frm; e.par = m_par;
    e.pend = (model_q.size() != 0);
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (int'(cfg_div)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit);
    @(negedge clk);
    model_frame(d, !stop_bit, cfg_par_en && bad_par);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    if (cfg_par_en) drive_bit((^d) ^ cfg_par_odd ^ bad_par);
    drive_bit(stop_bit);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    check("exp_ready", bus.exp_ready, model_q.size() < EXP_DEPTH);
    bus.exp_valid = 1'b1;
    bus.exp_data  = d;
    if (model_q.size() < EXP_DEPTH) model_q.push_back(d);
    @(negedge clk);
    bus.exp_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || mon_busy) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", sb.size() + int'(mon_busy), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_strobe"}, bus.rx_strobe, 0);
    check({tag, "_rx_data"}, bus.rx_data, 0);
    check({tag, "_match_cnt"}, match_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_flags"}, {err_mismatch, err_unexpected, err_frame, err_parity, timeout}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pending"}, pending, 0);
    check({tag, "_exp_ready"}, bus.exp_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_i  = 1'b1;
    bus.exp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    model_clear();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rx_strobe === 1'b1) begin
        strobe_count++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: rx_data=0x%02h, no frame expected", bus.rx_data);
        end else begin
          mon_busy = 1'b1;
          e = sb.pop_front();
          check("rx_data", bus.rx_data, e.data);
          @(negedge clk);
          check("match_cnt", match_cnt, e.match);
          check("err_cnt", err_cnt, e.err);
          check("err_mismatch", err_mismatch, e.mis);
          check("err_unexpected", err_unexpected, e.unexp);
          check("err_frame", err_frame, e.frm);
          check("err_parity", err_parity, e.par);
          check("pending", pending, e.pend);
          $display("frame rx_data=0x%02h match_cnt=%0d err_cnt=%0d flags(m,u,f,p)=%b%b%b%b",
                   bus.rx_data, match_cnt, err_cnt, err_mismatch, err_unexpected,
                   err_frame, err_parity);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] t5_data [EXP_DEPTH];
    logic [7:0] d;
    int         sc;

    reset = 1'b1; rx_i = 1'b1; cfg_div = 16'd8;
    cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    bus.exp_valid = 1'b0; bus.exp_data = '0;
    model_clear();
    do_reset();

    // Two matching frames, no parity.
    sc = strobe_count;
    push_byte(8'h55);
    push_byte(8'hA3);
    send_frame(8'h55, 0, 1);
    send_frame(8'hA3, 0, 1);
    wait_drain();
    check("t1_strobes", strobe_count - sc, 2);
    check("t1_match_cnt", match_cnt, 2);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_pending", pending, 0);

    // Data mismatch.
    do_reset();
    push_byte(8'h41);
    send_frame(8'h42, 0, 1);
    wait_drain();
    check("t2_err_mismatch", err_mismatch, 1);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_match_cnt", match_cnt, 0);
    check("t2_rx_data", bus.rx_data, 8'h42);

    // Even parity, wrong parity bit (0x07 needs parity 1).
    do_reset();
    cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
    push_byte(8'h07);
    send_frame(8'h07, 1, 1);
    wait_drain();
    check("t3_err_parity", err_parity, 1);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_pending", pending, 0);
    check("t3_match_cnt", match_cnt, 0);
    cfg_par_en = 1'b0;

    // Framing error with empty FIFO, then recovery.
    do_reset();
    send_frame(8'h10, 0, 0);
    wait_drain();
    check("t4_err_frame", err_frame, 1);
    check("t4_err_unexpected", err_unexpected, 1);
    check("t4_err_cnt", err_cnt, 1);
    push_byte(8'h11);
    send_frame(8'h11, 0, 1);
    wait_drain();
    check("t4_match_cnt", match_cnt, 1);

    // Fill the FIFO, overflow push, drain it all, then a short glitch.
    do_reset();
    for (int i = 0; i < EXP_DEPTH; i++) begin
      t5_data[i] = 8'($urandom);
      push_byte(t5_data[i]);
    end
    check("t5_full_ready", bus.exp_ready, 0);
    push_byte(8'h5A);
    for (int i = 0; i < EXP_DEPTH; i++) send_frame(t5_data[i], 0, 1);
    wait_drain();
    check("t5_match_cnt", match_cnt, EXP_DEPTH);
    check("t5_err_cnt", err_cnt, 0);
    sc = strobe_count;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (2) @(negedge clk);
    rx_i = 1'b1;
    repeat (4 * 8) @(negedge clk);
    check("t5_glitch_strobes", strobe_count - sc, 0);
    check("t5_glitch_busy", busy, 0);

    // Randomized frames against the reference model.
    do_reset();
    for (int r = 0; r < 24; r++) begin
      if (r % 6 == 0) begin
        cfg_div     = 16'($urandom_range(4, 12));
        cfg_par_en  = 1'($urandom_range(0, 1));
        cfg_par_odd = 1'($urandom_range(0, 1));
      end
      for (int p = $urandom_range(0, 2); p > 0; p--) push_byte(8'($urandom));
      if (model_q.size() != 0 && $urandom_range(0, 3) != 0) d = model_q[0];
      else d = 8'($urandom);
      send_frame(d, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
      wait_drain();
    end

    // Idle timeout, then reset in the middle of a frame.
    do_reset();
    cfg_div = 16'd8; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    push_byte(8'hFF);
    repeat (60 * 8) @(negedge clk);
    check("t6_timeout_early", timeout, 0);
    repeat (10 * 8) @(negedge clk);
    check("t6_timeout_set", timeout, 1);
    check("t6_fifo_kept", pending, 1);
    sc = strobe_count;
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
    check("t6_busy_mid_frame", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("t6_midframe");
    reset = 1'b0;
    model_clear();
    repeat (8 * 8) @(negedge clk);
    check("t6_no_strobe", strobe_count - sc, 0);
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
